// File: rtl/boot_hex_stream_loader.sv
// boot_hex_stream_loader
//   Turns a hex-dump-style character stream from the UART receiver into
//   address/data word writes for the boot memory. It accepts '@' address
//   records, data tokens of any length up to one word, and '//' comments.
//   A long idle gap ends the download: the parser goes back to IDLE, the
//   error report is cleared and the write address returns to zero.
//
// Ports
//   clk          single clock; all logic runs on the rising edge
//   reset        asynchronous, active-high
//   in_valid     one-cycle strobe that marks in_char as valid
//   in_char      received character
//   out_valid    a word is waiting in the output register
//   out_ready    the consumer takes the word when out_valid & out_ready
//   out_address  byte address of out_data
//   out_data     word, zero-extended on the left
//   busy         the idle-timeout counter is nonzero
//   error        sticky error flag
//   error_code   0 none, 1 illegal char, 2 token too long, 3 output overrun
module boot_hex_stream_loader #(
    parameter int address_width      = 32,
    parameter int data_width         = 32,
    parameter int char_width         = 8,
    parameter int address_step       = data_width / 8,
    parameter int clk_frequency      = 50000000,
    parameter int timeout_in_seconds = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [char_width-1:0]    in_char,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [address_width-1:0] out_address,
    output logic [data_width-1:0]    out_data,
    output logic                     busy,
    output logic                     error,
    output logic [1:0]               error_code
);

    localparam int data_nibs      = data_width / 4;
    localparam int addr_nibs      = (address_width + 3) / 4;
    localparam int acc_width      = (4 * addr_nibs > data_width) ? 4 * addr_nibs : data_width;
    localparam int max_nibs       = (data_nibs > addr_nibs) ? data_nibs : addr_nibs;
    localparam int nib_width      = $clog2(max_nibs + 1);
    localparam int timeout_cycles = timeout_in_seconds * clk_frequency;
    localparam int count_width    = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    localparam logic [acc_width+31:0] step_wide = (acc_width + 32)'(address_step);

    typedef enum logic [2:0] {IDLE, DATA, ADDR, SLASH, COMMENT, ERROR} state_t;

    state_t                   state_reg, state_next, cur_state;
    logic [acc_width-1:0]     acc_reg, acc_next;
    logic [nib_width-1:0]     nib_reg, nib_next;
    logic [address_width-1:0] addr_reg, addr_next;
    logic                     error_reg, error_next;
    logic [1:0]               code_reg, code_next;
    logic                     out_valid_reg, out_valid_next;
    logic [data_width-1:0]    out_data_reg, out_data_next;
    logic [address_width-1:0] out_address_reg, out_address_next;
    logic [count_width-1:0]   count_reg;

    // Character classification
    logic       is_digit, is_lower, is_upper, is_hex, is_space, is_at, is_slash, is_lf;
    logic [3:0] nibble;
    logic       expired, can_load, do_emit, raise, too_long;
    logic [1:0] raise_code;

    always_comb begin
        is_digit = (in_char >= char_width'(8'h30)) && (in_char <= char_width'(8'h39));
        is_lower = (in_char >= char_width'(8'h61)) && (in_char <= char_width'(8'h66));
        is_upper = (in_char >= char_width'(8'h41)) && (in_char <= char_width'(8'h46));
        is_hex   = is_digit || is_lower || is_upper;
        is_lf    = (in_char == char_width'(8'h0A));
        is_space = (in_char == char_width'(8'h20)) || (in_char == char_width'(8'h09)) ||
                   (in_char == char_width'(8'h0D)) || is_lf;
        is_at    = (in_char == char_width'(8'h40));
        is_slash = (in_char == char_width'(8'h2F));
        // 'a'/'A' have low nibble 1, so letters map to low nibble + 9.
        nibble   = is_digit ? in_char[3:0] : 4'(in_char[3:0] + 4'd9);
    end

    // An expired counter (including straight out of reset) means the stream
    // is idle: the parser is forced back to a clean IDLE state.
    assign expired  = (count_reg == '0);
    assign can_load = !out_valid_reg || out_ready;

    always_comb begin
        state_next       = state_reg;
        acc_next         = acc_reg;
        nib_next         = nib_reg;
        addr_next        = addr_reg;
        error_next       = error_reg;
        code_next        = code_reg;
        out_valid_next   = out_valid_reg && !out_ready;
        out_data_next    = out_data_reg;
        out_address_next = out_address_reg;
        do_emit          = 1'b0;
        raise            = 1'b0;
        raise_code       = 2'd0;
        too_long         = 1'b0;
        cur_state        = expired ? IDLE : state_reg;

        if (expired) begin
            state_next = IDLE;
            acc_next   = '0;
            nib_next   = '0;
            addr_next  = '0;
            error_next = 1'b0;
            code_next  = 2'd0;
        end

        if (in_valid) begin
            case (cur_state)
                IDLE: begin
                    if (is_hex) begin
                        state_next = DATA;
                        acc_next   = acc_width'(nibble);
                        nib_next   = nib_width'(1);
                    end else if (is_at) begin
                        state_next = ADDR;
                        acc_next   = '0;
                        nib_next   = '0;
                    end else if (is_slash) begin
                        state_next = SLASH;
                    end else if (!is_space) begin
                        raise      = 1'b1;
                        raise_code = 2'd1;
                    end
                end
                DATA: begin
                    if (is_hex) begin
                        too_long = (nib_reg == nib_width'(data_nibs));
                        acc_next = {acc_reg[acc_width-5:0], nibble};
                        nib_next = nib_reg + nib_width'(1);
                    end else if (is_space || is_slash) begin
                        do_emit    = 1'b1;
                        state_next = is_slash ? SLASH : IDLE;
                    end else begin
                        raise      = 1'b1;
                        raise_code = 2'd1;
                    end
                end
                ADDR: begin
                    if (is_hex) begin
                        too_long = (nib_reg == nib_width'(addr_nibs));
                        acc_next = {acc_reg[acc_width-5:0], nibble};
                        nib_next = nib_reg + nib_width'(1);
                    end else if (is_space && nib_reg != '0) begin
                        // Address records carry a word index, not a byte address.
                        addr_next  = address_width'({32'b0, acc_reg} * step_wide);
                        state_next = IDLE;
                    end else begin
                        raise      = 1'b1;
                        raise_code = 2'd1;
                    end
                end
                SLASH: begin
                    if (is_slash) begin
                        state_next = COMMENT;
                    end else begin
                        raise      = 1'b1;
                        raise_code = 2'd1;
                    end
                end
                COMMENT: begin
                    if (is_lf) state_next = IDLE;
                end
                default: ; // ERROR: input ignored until the timeout clears it
            endcase

            if (too_long) begin
                raise      = 1'b1;
                raise_code = 2'd2;
            end

            if (do_emit) begin
                if (can_load) begin
                    out_valid_next   = 1'b1;
                    out_data_next    = acc_reg[data_width-1:0];
                    out_address_next = addr_reg;
                    addr_next        = addr_reg + address_width'(address_step);
                end else begin
                    raise      = 1'b1;
                    raise_code = 2'd3;
                end
            end

            // Only reachable from non-ERROR states, so the first cause sticks.
            if (raise) begin
                state_next = ERROR;
                error_next = 1'b1;
                code_next  = raise_code;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            acc_reg         <= '0;
            nib_reg         <= '0;
            addr_reg        <= '0;
            error_reg       <= 1'b0;
            code_reg        <= 2'd0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_address_reg <= '0;
            count_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            acc_reg         <= acc_next;
            nib_reg         <= nib_next;
            addr_reg        <= addr_next;
            error_reg       <= error_next;
            code_reg        <= code_next;
            out_valid_reg   <= out_valid_next;
            out_data_reg    <= out_data_next;
            out_address_reg <= out_address_next;
            if (in_valid)
                count_reg <= count_width'(timeout_cycles);
            else if (count_reg != '0)
                count_reg <= count_reg - count_width'(1);
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign out_address = out_address_reg;
    assign busy        = (count_reg != '0);
    assign error       = error_reg;
    assign error_code  = code_reg;

endmodule

// File: tb/tb_boot_hex_stream_loader.sv
module tb_boot_hex_stream_loader;

    localparam int N = 20; // timeout cycles: 1 s at a 20 Hz "clock"

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_address;
    logic [31:0] out_data;
    logic        busy;
    logic        error;
    logic [1:0]  error_code;

    int vectors = 0;
    int miscompares = 0;
    int accepted = 0;
    int acc_mark;

    boot_hex_stream_loader #(
        .address_width(32), .data_width(32), .char_width(8), .address_step(4),
        .clk_frequency(N), .timeout_in_seconds(1)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
        .out_valid(out_valid), .out_ready(out_ready), .out_address(out_address),
        .out_data(out_data), .busy(busy), .error(error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    // Count completed handshakes so transient words cannot go unnoticed.
    always @(posedge clk)
        if (!reset && out_valid && out_ready) accepted <= accepted + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vector %0d %s: observed %h expected %h", vectors, tag, obs, exp);
    endtask

    // One character per clock; returns #1 after the sampling edge.
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_char  = s[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle_out();
        repeat (N + 3) @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d, input logic [31:0] a);
        check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, ".data"}, out_data, d);
        check({tag, ".addr"}, out_address, a);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", {31'b0, out_valid}, 32'd0);
        check("rst.addr", out_address, 32'd0);
        check("rst.data", out_data, 32'd0);
        check("rst.error", {31'b0, error}, 32'd0);
        check("rst.code", {30'b0, error_code}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Two consecutive data words
        send_str("12345678\n");
        check_word("w1", 32'h12345678, 32'h0);
        check("w1.busy", {31'b0, busy}, 32'd1);
        send_str("a");
        check("w1.drained", {31'b0, out_valid}, 32'd0);
        send_str("b ");
        check_word("w2", 32'h000000AB, 32'h4);
        // busy falls exactly N cycles after the last in_valid
        repeat (N - 1) @(posedge clk);
        #1;
        check("busy.before", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("busy.after", {31'b0, busy}, 32'd0);
        idle_out();

        // Address record
        send_str("@10\nDEADBEEF\n");
        check_word("w3", 32'hDEADBEEF, 32'h40);
        send_str("1\n");
        check_word("w4", 32'h00000001, 32'h44);
        idle_out();

        // Comment line
        acc_mark = accepted;
        send_str("// note 9\n");
        check("cmt.words", accepted - acc_mark, 32'd0);
        check("cmt.error", {31'b0, error}, 32'd0);
        send_str("5\n");
        check_word("w5", 32'h00000005, 32'h0);
        idle_out();
        check("cmt.count", accepted - acc_mark, 32'd1);

        // Token too long, then timeout recovery
        acc_mark = accepted;
        send_str("123456789");
        check("long.error", {31'b0, error}, 32'd1);
        check("long.code", {30'b0, error_code}, 32'd2);
        send_str("\n");
        check("long.valid", {31'b0, out_valid}, 32'd0);
        idle_out();
        check("long.words", accepted - acc_mark, 32'd0);
        check("long.cleared", {31'b0, error}, 32'd0);
        check("long.codeclr", {30'b0, error_code}, 32'd0);
        check("long.busy", {31'b0, busy}, 32'd0);
        send_str("7\n");
        check_word("w6", 32'h00000007, 32'h0);
        idle_out();

        // Illegal characters
        send_str("g");
        check("ill.code", {30'b0, error_code}, 32'd1);
        idle_out();
        send_str("@ ");
        check("ataddr.code", {30'b0, error_code}, 32'd1);
        idle_out();

        // Output overrun under backpressure
        out_ready = 1'b0;
        acc_mark = accepted;
        send_str("1 ");
        check_word("ovr.w", 32'h1, 32'h0);
        send_str("2 ");
        check("ovr.error", {31'b0, error}, 32'd1);
        check("ovr.code", {30'b0, error_code}, 32'd3);
        check_word("ovr.held", 32'h1, 32'h0);
        send_str("3 ");
        check("ovr.codekeep", {30'b0, error_code}, 32'd3);
        check("ovr.held3", out_data, 32'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr.drained", {31'b0, out_valid}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("ovr.words", accepted - acc_mark, 32'd1);
        check("ovr.novalid", {31'b0, out_valid}, 32'd0);
        idle_out();

        // Reset mid-token
        send_str("ABC");
        #2;
        reset = 1'b1;
        #1;
        check("mrst.busy", {31'b0, busy}, 32'd0);
        check("mrst.valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_str("D\n");
        check_word("w7", 32'h0000000D, 32'h0);
        idle_out();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/boot_hex_stream_loader.md
# boot_hex_stream_loader

Parametrised successor to the boot hex parser: converts a UART character stream in `$readmemh` style into address/data word writes for boot memory. Supports `@` address records, variable-length data tokens, `//` comments, `out_ready` backpressure and a coded error report. Sits between the UART receiver and the boot-memory write port. Idle timeout marks end of download and resynchronises the parser.

## Interface
- `address_width`, 32, width of `out_address` (byte address)
- `data_width`, 32, word width; must be a multiple of 4
- `char_width`, 8, UART character width
- `address_step`, `data_width / 8`, byte increment between consecutive words
- `clk_frequency`, 50000000, clock in Hz
- `timeout_in_seconds`, 1, idle time that ends a download

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  asynchronous, active-high
- `in_valid`  in  1  one-cycle strobe, `in_char` valid
- `in_char`  in  `char_width`  received character
- `out_valid`  out  1  word available
- `out_ready`  in  1  consumer accepts word when `out_valid & out_ready`
- `out_address`  out  `address_width`  byte address of `out_data`
- `out_data`  out  `data_width`  word, zero-extended on the left
- `busy`  out  1  timeout counter nonzero
- `error`  out  1  sticky error flag
- `error_code`  out  2  0 none, 1 illegal char, 2 token too long, 3 output overrun

## Operation
- Character classes: hex digit (`0-9 a-f A-F`), whitespace (space, TAB, CR, LF), `@`, `/`; anything else is illegal.
- FSM states: IDLE (between tokens), DATA, ADDR, SLASH, COMMENT, ERROR.
- IDLE: hex → DATA, load nibble; `@` → ADDR, clear accumulator; `/` → SLASH; whitespace stays; illegal → ERROR code 1.
- DATA: hex shifts in nibble (acc = acc<<4 | nibble); whitespace emits word, → IDLE; `/` emits word, → SLASH; other → ERROR code 1.
- ADDR: hex shifts in; whitespace with ≥1 nibble loads word index, → IDLE; whitespace with 0 nibbles or other char → ERROR code 1.
- Byte address register = word index × `address_step`, truncated to `address_width`.
- SLASH: `/` → COMMENT; else → ERROR code 1. COMMENT: all chars ignored until LF → IDLE.
- Nibble counter per token; more than `data_width/4` nibbles (DATA) or `address_width/4` rounded up (ADDR) → ERROR code 2; no word emitted.
- Emit: if output register empty or being drained this cycle, load `out_data`/`out_address`, then address register += `address_step` (wraps modulo 2^`address_width`). Else → ERROR code 3, word dropped, address unchanged.
- ERROR: `error` = 1, `error_code` holds first cause; all input ignored; no new words. Pending output word still drains.
- Timeout: counter reloads to `timeout_in_seconds * clk_frequency` on each `in_valid`, decrements to 0; width `$clog2(N+1)`. At 0: FSM → IDLE, partial token discarded, error and code cleared, address register → 0.

## Timing
- Reset values: `out_valid` 0, `out_address` 0, `out_data` 0, `error` 0, `error_code` 0, `busy` 0, FSM IDLE, address register 0.
- Word latency: `out_valid` rises the cycle after the terminating character's `in_valid`.
- `out_valid` holds with stable address/data until `out_ready`; falls the cycle after handshake unless a new word loads the same cycle (back-to-back allowed).
- `error` rises the cycle after the offending character.
- `busy` rises the cycle after first `in_valid`; falls exactly N cycles after the last `in_valid`.
- Timeout reaching 0 and `in_valid` in the same cycle: character processed from IDLE with error cleared.
- Reset mid-token: everything returns to reset values asynchronously; no word emitted.

## Test plan
- "12345678\n" then "ab " → word 0x12345678 @0x0, then 0x000000AB @0x4, each one cycle after the terminator.
- "@10\nDEADBEEF\n" → word 0xDEADBEEF @0x40; next "1\n" → 0x00000001 @0x44.
- "// note 9\n5\n" → single word 0x00000005 @0x0; no error.
- "123456789\n" → `error`=1, code 2, no word; after N idle cycles `error`=0, `busy`=0; then "7\n" → 0x7 @0x0.
- `out_ready`=0, "1 2 3 " → 0x1 @0x0 held, second word → code 3; `out_ready`=1 drains 0x1, no further words.
- Reset asserted after "ABC" → outputs reset; "D\n" after release → 0x0000000D @0x0.
